// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - multi-channel runtime-programmable clock divider
//
// Purpose:
//   NUM_CH independent dividers running off clk_50mhz. Each channel produces a
//   registered square wave (high for ceil(N/2), low for floor(N/2) enabled
//   cycles) and a one-cycle tick at the end of every period. Divisors are
//   written through a small write port; sync restarts every channel at phase 0.
//
// Build option:
//   CLKDIV_SHADOW_EN defined   : writes land in a per-channel shadow register
//                                and are applied at the next period boundary
//                                (or on sync); pending flags the wait.
//   CLKDIV_SHADOW_EN undefined : a write restarts its channel with the new
//                                divisor on the next cycle; pending is 0.
//
// Ports:
//   clk_50mhz  in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset, dominates all inputs
//   en         in   NUM_CH  per-channel count enable
//   sync       in   1       restart all channels at phase 0
//   wr_en      in   1       divisor write strobe
//   wr_ch      in   CH_W    write target channel (>= NUM_CH ignored)
//   wr_div     in   DIV_W   new divisor (values below 2 act as 2)
//   clk_out    out  NUM_CH  divided clocks (registered)
//   tick       out  NUM_CH  one-cycle strobe per output period (registered)
//   pending    out  NUM_CH  written divisor awaiting its period boundary

module clock_divider_bank #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int DIV_W       = 32,
   parameter int DEFAULT_DIV = 50000
) (
   input  logic              clk_50mhz,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [DIV_W-1:0]  wr_div,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending
);

   localparam int               L_DEF_INT = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
   localparam logic [DIV_W-1:0] L_DEF_DIV = DIV_W'(L_DEF_INT);
   localparam logic [DIV_W-1:0] L_TWO     = DIV_W'(2);
   localparam logic [DIV_W-1:0] L_ONE     = DIV_W'(1);

   // Divisors are always stored already clamped, so the counter logic never
   // has to deal with N < 2.
   function automatic logic [DIV_W-1:0] f_clamp(input logic [DIV_W-1:0] v);
      return (v < L_TWO) ? L_TWO : v;
   endfunction

   logic [DIV_W-1:0]  r_cnt [NUM_CH];
   logic [DIV_W-1:0]  r_div [NUM_CH];
   logic [NUM_CH-1:0] r_clk;
   logic [NUM_CH-1:0] r_tick;

`ifdef CLKDIV_SHADOW_EN
   logic [DIV_W-1:0]  r_shadow [NUM_CH];
   logic [NUM_CH-1:0] r_pending;
`endif

   logic [DIV_W-1:0]  w_half [NUM_CH];
   logic [NUM_CH-1:0] w_last;
   logic [NUM_CH-1:0] w_hi;
   logic [NUM_CH-1:0] w_hit;

   always_comb begin
      w_half = '{default: '0};
      w_last = '0;
      w_hi   = '0;
      w_hit  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         // An out-of-range wr_ch matches no channel, so it is dropped here.
         w_hit[i]  = wr_en && (wr_ch == CH_W'(i));
         // ceil(N/2) without the overflow that (N+1)>>1 would risk at full width.
         w_half[i] = (r_div[i] >> 1) + DIV_W'(r_div[i][0]);
         // >= rather than == so a corrupted counter still wraps within a period.
         w_last[i] = (r_cnt[i] >= (r_div[i] - L_ONE));
         w_hi[i]   = (r_cnt[i] < w_half[i]);
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i] <= '0;
            r_div[i] <= L_DEF_DIV;
`ifdef CLKDIV_SHADOW_EN
            r_shadow[i] <= '0;
`endif
         end
         r_clk  <= '0;
         r_tick <= '0;
`ifdef CLKDIV_SHADOW_EN
         r_pending <= '0;
`endif
      end else if (sync) begin
         // Phase-aligned restart of every channel, enabled or not.
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i] <= '0;
`ifdef CLKDIV_SHADOW_EN
            // A write arriving with sync is newer than anything in the shadow.
            if (w_hit[i]) begin
               r_div[i]    <= f_clamp(wr_div);
               r_shadow[i] <= wr_div;
            end else if (r_pending[i]) begin
               r_div[i] <= f_clamp(r_shadow[i]);
            end
`else
            if (w_hit[i]) begin
               r_div[i] <= f_clamp(wr_div);
            end
`endif
         end
         r_clk  <= '0;
         r_tick <= '0;
`ifdef CLKDIV_SHADOW_EN
         r_pending <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
`ifdef CLKDIV_SHADOW_EN
            if (en[i]) begin
               r_cnt[i]  <= w_last[i] ? '0 : (r_cnt[i] + L_ONE);
               r_clk[i]  <= w_hi[i];
               r_tick[i] <= w_last[i];
               // Swap divisors only as the period closes, so no runt pulse.
               if (w_last[i] && r_pending[i]) begin
                  r_div[i]     <= f_clamp(r_shadow[i]);
                  r_pending[i] <= 1'b0;
               end
            end else begin
               r_tick[i] <= 1'b0;
            end
            // Placed after the boundary swap: a write in the boundary cycle
            // keeps pending set and waits for the following boundary.
            if (w_hit[i]) begin
               r_shadow[i]  <= wr_div;
               r_pending[i] <= 1'b1;
            end
`else
            if (w_hit[i]) begin
               r_div[i]  <= f_clamp(wr_div);
               r_cnt[i]  <= '0;
               r_clk[i]  <= 1'b0;
               r_tick[i] <= 1'b0;
            end else if (en[i]) begin
               r_cnt[i]  <= w_last[i] ? '0 : (r_cnt[i] + L_ONE);
               r_clk[i]  <= w_hi[i];
               r_tick[i] <= w_last[i];
            end else begin
               r_tick[i] <= 1'b0;
            end
`endif
         end
      end
   end

   assign clk_out = r_clk;
   assign tick    = r_tick;
`ifdef CLKDIV_SHADOW_EN
   assign pending = r_pending;
`else
   assign pending = '0;
`endif

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - randomized self-checking bench for clock_divider_bank
module tb_clock_divider_bank;

   localparam int NCH  = 4;
   localparam int CHW  = 3;
   localparam int DW   = 32;
   localparam int DEFD = 4;
`ifdef CLKDIV_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic           clk_50mhz = 1'b0;
   logic           rst;
   logic [NCH-1:0] en;
   logic           sync;
   logic           wr_en;
   logic [CHW-1:0] wr_ch;
   logic [DW-1:0]  wr_div;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] pending;

   always #10 clk_50mhz = ~clk_50mhz;

   clock_divider_bank #(
      .NUM_CH      (NCH),
      .CH_W        (CHW),
      .DIV_W       (DW),
      .DEFAULT_DIV (DEFD)
   ) dut (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_div    (wr_div),
      .clk_out   (clk_out),
      .tick      (tick),
      .pending   (pending)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: each channel holds the remaining waveform of its current
   // period as a queue of levels; a new period is generated from N on demand.
   int unsigned    m_n    [NCH];
   logic [DW-1:0]  m_sh   [NCH];
   bit             m_pend [NCH];
   bit             m_wave [NCH][$];
   logic [NCH-1:0] m_clk  = '0;
   logic [NCH-1:0] m_tick = '0;

   function automatic int unsigned clamp2(input logic [DW-1:0] v);
      return (v < 2) ? 2 : int'(v);
   endfunction

   task automatic model_edge();
      for (int c = 0; c < NCH; c++) begin
         bit hit;
         hit = wr_en && (wr_ch == CHW'(c));
         if (rst) begin
            m_n[c] = DEFD; m_sh[c] = '0; m_pend[c] = 0;
            m_wave[c].delete(); m_clk[c] = 0; m_tick[c] = 0;
         end else if (sync) begin
            m_wave[c].delete(); m_clk[c] = 0; m_tick[c] = 0;
            if (hit) m_n[c] = clamp2(wr_div);
            else if (SHADOW && m_pend[c]) m_n[c] = clamp2(m_sh[c]);
            m_pend[c] = 0;
         end else if (!SHADOW && hit) begin
            m_n[c] = clamp2(wr_div);
            m_wave[c].delete(); m_clk[c] = 0; m_tick[c] = 0;
         end else begin
            if (en[c]) begin
               if (m_wave[c].size() == 0)
                  for (int k = 0; k < int'(m_n[c]); k++)
                     m_wave[c].push_back(k < int'((m_n[c] + 1) / 2));
               m_clk[c]  = m_wave[c].pop_front();
               m_tick[c] = (m_wave[c].size() == 0);
               if (m_tick[c] && m_pend[c]) begin
                  m_n[c] = clamp2(m_sh[c]);
                  m_pend[c] = 0;
               end
            end else begin
               m_tick[c] = 0;
            end
            if (SHADOW && hit) begin
               m_sh[c] = wr_div;
               m_pend[c] = 1;
            end
         end
      end
   endtask

   function automatic logic [NCH-1:0] m_pend_vec();
      logic [NCH-1:0] v;
      for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
      return v;
   endfunction

   task automatic step();
      @(posedge clk_50mhz);
      model_edge();
      @(negedge clk_50mhz);
      check("clk_out", 32'(clk_out), 32'(m_clk));
      check("tick",    32'(tick),    32'(m_tick));
      check("pending", 32'(pending), 32'(m_pend_vec()));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write(input int ch, input int div);
      wr_en = 1'b1; wr_ch = CHW'(ch); wr_div = DW'(div);
      step();
      wr_en = 1'b0;
   endtask

   int tick_cnt [NCH];
   int hi_cnt;

   initial begin
      rst = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
      for (int c = 0; c < NCH; c++) begin m_n[c] = DEFD; m_sh[c] = '0; m_pend[c] = 0; end
      @(negedge clk_50mhz);
      idle(2);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_pending", 32'(pending), 32'd0);

      // Default divisor 4, all channels enabled together.
      rst = 1'b0; en = 4'hF;
      for (int c = 0; c < NCH; c++) tick_cnt[c] = 0;
      hi_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         step();
         for (int c = 0; c < NCH; c++) tick_cnt[c] += int'(tick[c]);
         hi_cnt += int'(clk_out[0]);
         check("in_phase", 32'(clk_out == 4'h0 || clk_out == 4'hF), 32'd1);
      end
      for (int c = 0; c < NCH; c++) check("ticks_per_16", 32'(tick_cnt[c]), 32'd4);
      check("high_per_16", 32'(hi_cnt), 32'd8);

      // Directed scenarios, checked cycle by cycle against the model.
      idle(1);
      write(1, 5);
      idle(12);
      write(0, 0);
      write(0, 1);
      idle(8);
      en = 4'b1011;
      idle(7);
      en = 4'hF;
      idle(10);
      write(3, 6);
      idle(2);
      sync = 1'b1;
      write(0, 3);
      sync = 1'b0;
      check("sync_pending", 32'(pending), 32'd0);
      check("sync_clk_out", 32'(clk_out), 32'd0);
      idle(12);
      write(7, 9);
      check("ignored_wr_pending", 32'(pending), 32'd0);
      idle(5);
      write(2, 7);
      idle(1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_clk_out", 32'(clk_out), 32'd0);
      check("midrst_pending", 32'(pending), 32'd0);
      idle(10);

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         en     = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : 4'hF;
         wr_en  = ($urandom_range(0, 7) == 0);
         wr_ch  = CHW'($urandom_range(0, 7));
         wr_div = DW'($urandom_range(0, 9));
         sync   = ($urandom_range(0, 63) == 0);
         rst    = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Multi-channel, runtime-programmable clock divider driven by the 50 MHz board clock.
- Each of NUM_CH channels produces a divided square wave and a single-cycle tick strobe.
- Per-channel divisors are loaded through a simple write port, and a global sync restarts all channels phase-aligned.
- Feeds display scan, debounce and timekeeping logic that previously needed fixed, hard-coded rates.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- CH_W, 2: width of the channel-select field; must satisfy 2^CH_W >= NUM_CH.
- DIV_W, 32: width of divisor and counter registers.
- DEFAULT_DIV, 50000: divisor loaded into every channel at reset. Values below 2 are clamped to 2.

Ports:
- clk_50mhz  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel count enable.
- sync  in  1  restart all channels at phase 0.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CH_W  target channel for the write.
- wr_div  in  DIV_W  new divisor value.
- clk_out  out  NUM_CH  divided clocks (registered).
- tick  out  NUM_CH  one-cycle strobe per output period (registered).
- pending  out  NUM_CH  1 while a written divisor awaits its period boundary.

Behaviour:
- Clock and reset: one clock, clk_50mhz. Reset rst is synchronous and active-high, and dominates every other input.
- Reset values: cnt=0, div=max(DEFAULT_DIV,2), shadow=0, clk_out=0, tick=0, pending=0 for every channel.
- Divisor N: effective N = max(written value, 2).
  - Period is N enabled cycles.
  - clk_out is high for ceil(N/2) cycles and low for floor(N/2) cycles.
- Counter: while en[i]=1, cnt counts 0..N-1 and wraps to 0.
  - clk_out[i] is registered: the cycle after cnt=c, clk_out = (c < ceil(N/2)).
  - tick[i] is registered: it pulses for one cycle, the cycle after cnt=N-1.
  - Latency from counter to outputs is exactly one cycle.
- First cycle after reset release with en=1: cnt=0. clk_out rises on the next cycle.
- en[i]=0: cnt[i] and clk_out[i] hold, tick[i]=0. On re-enable, the channel resumes the same phase.
- Write, applied when wr_en=1 and wr_ch < NUM_CH:
  - shadow[wr_ch] <= wr_div and pending[wr_ch] <= 1.
  - A second write before the boundary overwrites shadow; pending stays 1.
  - wr_ch >= NUM_CH is ignored with no state change.
- Boundary: on the cycle where cnt=N-1 and en=1 with pending=1, div <= clamp(shadow), pending <= 0, and cnt wraps to 0. The next period uses the new N, so there are no runt pulses.
- sync=1, for all channels regardless of en:
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - Every pending shadow is applied and pending cleared.
  - A write in the same cycle is captured and applied immediately.
- Simultaneous write and boundary on the same channel: the new write goes to shadow and pending stays 1. The older shadow value is applied now; the new one is applied at the next boundary.
- Mid-operation reset: all state returns to reset values in the next cycle, and in-flight writes are discarded.
- Counter compares are unsigned, and cnt never exceeds N-1.

Optional Feature:
- Macro: CLKDIV_SHADOW_EN.
- Defined: shadow and pending behaviour as above, with glitch-free divisor changes at the period boundary.
- Not defined: a write takes effect on the next cycle.
  - div <= clamp(wr_div), cnt <= 0, clk_out <= 0, tick <= 0 for that channel.
  - No shadow register is built, and pending is tied to 0.

Test Plan:
- DEFAULT_DIV=4, en=4'hF after reset -> every clk_out has period 4, 2 high / 2 low, one tick per 4 cycles, and all channels are in phase.
- Write ch1 div=5 at cnt=1 -> pending[1]=1 for 3 cycles. The next ch1 period is 5 cycles (3 high, 2 low), and ch0/2/3 are unchanged.
- Write ch0 wr_div=0, then 1 -> ch0 runs at N=2, 1 high / 1 low, with a tick every 2 cycles.
- en[2]=0 for 7 cycles at cnt=2 -> clk_out[2] frozen and tick[2]=0. On re-enable, ch2 is 7 cycles behind ch3.
- Pending ch3 div=6, then sync=1 together with a write of ch0 div=3 -> the next cycle has all cnt=0 and pending=0. ch3 period is 6, ch0 period is 3, and rising edges align.
- Write wr_ch=7 with NUM_CH=4 -> no change. Then rst mid-period -> clk_out=0, tick=0, pending=0, and divisors return to DEFAULT_DIV.
